// File: rtl/uart_rx_fifo_if.sv
// CPU-side read port of uart_rx_fifo: read strobe, head byte and status flags.
interface uart_rx_fifo_if;
  logic       rd;
  logic [7:0] dout;
  logic       rdy;
  logic       ferr;
  logic       ovr;

  modport master (output rd, input dout, rdy, ferr, ovr);
  modport slave  (input rd, output dout, rdy, ferr, ovr);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling and a FWFT receive buffer.
// `UART_RX_FIFO_EN selects a DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DEPTH  = 4
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             rx,
  uart_rx_fifo_if.slave    bus
);

  localparam int unsigned DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [DW-1:0] dc;
  logic          tick;

  assign tick = (dc == DW'(DIV - 1));

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)       dc <= '0;
    else if (tick) dc <= '0;
    else           dc <= dc + 1'b1;
  end

  logic rx_m, rxs;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     st;
  logic [3:0] tc;
  logic [2:0] bc;
  logic [7:0] sh;
  logic       brk;
  logic       push;
  logic       ferr_q;

  // brk marks a failed stop bit: wait in STOP for the line to return high.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      tc     <= '0;
      bc     <= '0;
      sh     <= '0;
      brk    <= 1'b0;
      push   <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      push   <= 1'b0;
      ferr_q <= 1'b0;
      case (st)
        IDLE: begin
          if (!rxs) begin
            st <= START;
            tc <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tc == 4'd7) begin
              tc <= '0;
              bc <= '0;
              st <= rxs ? IDLE : DATA;
            end else begin
              tc <= tc + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tc <= tc + 4'd1;
            if (tc == 4'd15) begin
              sh <= {rxs, sh[7:1]};
              bc <= bc + 3'd1;
              if (bc == 3'd7) st <= STOP;
            end
          end
        end
        STOP: begin
          if (brk) begin
            if (rxs) begin
              brk <= 1'b0;
              st  <= IDLE;
            end
          end else if (tick) begin
            tc <= tc + 4'd1;
            if (tc == 4'd15) begin
              if (rxs) begin
                push <= 1'b1;
                st   <= IDLE;
              end else begin
                ferr_q <= 1'b1;
                brk    <= 1'b1;
              end
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.ferr = ferr_q;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wp, rp;
  logic [7:0]  mem [DEPTH];
  logic        full, empty, pop, wr;
  logic        ovr_q;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = bus.rd && !empty;
  assign wr    = push && (!full || pop);

  // On a full push+pop the write lands in the slot being vacated by the pop.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      ovr_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= sh;
        wp              <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (push && full && !pop) ovr_q <= 1'b1;
      else if (bus.rd)          ovr_q <= 1'b0;
    end
  end

  assign bus.dout = mem[rp[AW-1:0]];
  assign bus.rdy  = !empty;
  assign bus.ovr  = ovr_q;
`else
  logic [7:0] hold;
  logic       vld;
  logic       ovr_q;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      hold  <= '0;
      vld   <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (push) begin
        hold <= sh;
        vld  <= 1'b1;
      end else if (bus.rd) begin
        vld  <= 1'b0;
      end
      if (push && vld && !bus.rd) ovr_q <= 1'b1;
      else if (bus.rd)            ovr_q <= 1'b0;
    end
  end

  assign bus.dout = hold;
  assign bus.rdy  = vld;
  assign bus.ovr  = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames feed a queue model, a monitor checks every read.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ = 6400000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned BIT    = DIV * 16;
`ifdef UART_RX_FIFO_EN
  localparam int unsigned CAP       = DEPTH;
  localparam bit          OVERWRITE = 1'b0;
`else
  localparam int unsigned CAP       = 1;
  localparam bit          OVERWRITE = 1'b1;
`endif

  logic clk_50m = 1'b0;
  logic rst;
  logic rx;
  int   cyc = 0;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .rx      (rx),
    .bus     (bus)
  );

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_q[$];
  bit         m_ovr = 1'b0;
  int         ferr_exp = 0;
  int         ferr_seen = 0;
  int         ferr_w = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buffer behaviour as seen from the CPU: bounded queue, drop or overwrite when full.
  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < CAP) begin
      model_q.push_back(b);
    end else begin
      m_ovr = 1'b1;
      if (OVERWRITE) begin
        void'(model_q.pop_front());
        model_q.push_back(b);
      end
    end
  endtask

  always @(negedge clk_50m) begin
    if (rst) begin
      ferr_w = 0;
    end else begin
      if (bus.rd) begin
        if (bus.rdy) begin
          if (model_q.size() == 0) chk("rdy_unexpected", bus.rdy, 0);
          else                     chk("dout_on_rd", bus.dout, model_q.pop_front());
        end
        m_ovr = 1'b0;
      end
      if (bus.ferr) begin
        ferr_w++;
      end else if (ferr_w != 0) begin
        chk("ferr_width", ferr_w, 1);
        ferr_seen++;
        ferr_w = 0;
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk_50m);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (bad_stop) begin
      drive_bit(1'b0);
      drive_bit(1'b1);
      ferr_exp++;
    end else begin
      drive_bit(1'b1);
      model_push(b);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_rdy"}, bus.rdy, model_q.size() != 0);
    chk({tag, "_ovr"}, bus.ovr, m_ovr);
    chk({tag, "_ferr_count"}, ferr_seen, ferr_exp);
    if (model_q.size() != 0) chk({tag, "_dout"}, bus.dout, model_q[0]);
  endtask

  task automatic read_one();
    @(posedge clk_50m); #1;
    bus.rd = 1'b1;
    @(posedge clk_50m); #1;
    bus.rd = 1'b0;
    chk("rdy_after_rd", bus.rdy, model_q.size() != 0);
    chk("ovr_after_rd", bus.ovr, m_ovr);
    if (model_q.size() != 0) chk("dout_after_rd", bus.dout, model_q[0]);
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int k = 0; k < int'(CAP) + 4; k++) begin
      if (!bus.rdy) break;
      read_one();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},  bus.rdy,  1'b0);
    chk({tag, "_dout"}, bus.dout, 8'h00);
    chk({tag, "_ferr"}, bus.ferr, 1'b0);
    chk({tag, "_ovr"},  bus.ovr,  1'b0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int t0;
    bit hit;
    logic [7:0] b;

    rst    = 1'b1;
    rx     = 1'b1;
    bus.rd = 1'b0;
    repeat (5) @(posedge clk_50m);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (10) @(posedge clk_50m);
    #1;

    // Single byte and rdy latency (~9.5 bit times after the start edge)
    lat = -1;
    t0  = cyc;
    fork
      send_frame(8'h41, 1'b0);
      begin
        for (int k = 0; k < int'(12 * BIT); k++) begin
          @(negedge clk_50m);
          if (bus.rdy) begin
            lat = cyc - t0;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < int'(BIT * 19 / 2) - 4 || lat > int'(BIT * 19 / 2 + DIV) + 8) begin
      errors++;
      $display("FAIL rdy_latency: got %0d cycles expected %0d..%0d", lat,
               int'(BIT * 19 / 2) - 4, int'(BIT * 19 / 2 + DIV) + 8);
    end
    check_state("byte41");
    read_one();

    // Short low glitch on the idle line
    rx = 1'b0;
    repeat (BIT / 3) @(posedge clk_50m);
    #1;
    rx = 1'b1;
    repeat (2 * BIT) @(posedge clk_50m);
    #1;
    check_state("glitch");
    send_frame(8'h0D, 1'b0);
    check_state("byte0d");
    read_one();

    // Framing error, then a clean frame
    send_frame(8'h55, 1'b1);
    check_state("ferr55");
    send_frame(8'h33, 1'b0);
    check_state("byte33");
    read_one();

    // Overflow the buffer with no reads
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0);
    check_state("overflow");
    chk("overflow_ovr_set", bus.ovr, 1'b1);
    drain(n);

    // Full buffer, read strobe exactly on the push cycle
    for (int i = 0; i < int'(CAP); i++) send_frame(8'h30 + 8'(i), 1'b0);
    hit = 1'b0;
    fork
      send_frame(8'h20, 1'b0);
      begin
        for (int k = 0; k < int'(12 * BIT); k++) begin
          @(posedge clk_50m); #1;
          if (dut.push) begin
            bus.rd = 1'b1;
            @(posedge clk_50m); #1;
            bus.rd = 1'b0;
            hit = 1'b1;
            break;
          end
        end
      end
    join
    chk("push_cycle_seen", hit, 1'b1);
    check_state("full_rdpush");
    chk("full_rdpush_ovr_clear", bus.ovr, 1'b0);
    drain(n);
    chk("full_rdpush_remaining", n, CAP);

    // Reset in the middle of data bit 3
    send_frame(8'h66, 1'b0);
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx = b[3];
    repeat (BIT / 2) @(posedge clk_50m);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    model_q.delete();
    m_ovr = 1'b0;
    repeat (3) @(posedge clk_50m);
    #1;
    check_reset_outputs("midframe_rst");
    rst = 1'b0;
    repeat (2 * BIT) @(posedge clk_50m);
    #1;
    check_state("after_rst");
    send_frame(8'h7E, 1'b0);
    check_state("byte7e");
    read_one();

    // Randomised bursts of frames and reads
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, CAP + 2);
      for (int i = 0; i < n; i++)
        send_frame(8'($urandom), ($urandom_range(0, 5) == 0));
      check_state("rand_burst");
      n = $urandom_range(0, model_q.size() + 1);
      for (int i = 0; i < n; i++) read_one();
    end
    drain(n);
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Asynchronous serial receiver for the board-level serial input (8N1, LSB first) with a small first-word-fall-through receive buffer. It sits directly behind the `ser_rx` pad in the `ws_ep4ce10` top level. It synchronises the line, recovers characters with 16x oversampling, and presents bytes to the CPU-side peripheral bus through a read strobe.

## Interface
Parameters:
- `CLK_HZ`, 50000000, system clock frequency in Hz
- `BAUD`, 9600, line bit rate
- `DEPTH`, 4, receive FIFO depth in bytes; must be a power of two, at least 2; used only with `UART_RX_FIFO_EN`

Ports:
- `clk_50m`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `rx`  in  1  serial line, asynchronous to `clk_50m`, idle high
- `rd`  in  1  read strobe; pops the head byte when `rdy`=1
- `dout`  out  8  head byte; valid while `rdy`=1
- `rdy`  out  1  at least one byte is buffered
- `ferr`  out  1  one-cycle pulse on a framing error (stop bit sampled low)
- `ovr`  out  1  sticky overrun flag; cleared by any `rd` pulse

## Operation
- Tick generator:
  - `DIV = (CLK_HZ + BAUD*8) / (BAUD*16)`, integer division, so 326 at the defaults.
  - One-cycle `tick` every `DIV` clocks, free-running.
- Input path:
  - Two-flop synchroniser on `rx`, with reset value 1.
  - All state-machine decisions use the synchronised value `rxs`.
- FSM `IDLE → START → DATA → STOP → IDLE`, with a tick counter `tc[3:0]` and a bit counter `bc[2:0]`:
  - IDLE: when `rxs`=0, go to START and clear `tc`.
  - START: after 8 ticks, sample `rxs`. If it is 1, the edge was a glitch: return to IDLE and push nothing. If it is 0, go to DATA with `tc`=0 and `bc`=0.
  - DATA: every 16 ticks, shift `rxs` into `sh[7]`, moving the existing bits right. After `bc`=7, go to STOP.
  - STOP: after 16 ticks, sample `rxs`. If it is 1, push `sh`. If it is 0, pulse `ferr`, discard the byte, and stay in STOP until `rxs`=1, then go to IDLE.
- FIFO (`UART_RX_FIFO_EN`):
  - Pointers are `$clog2(DEPTH)+1` bits wide; the extra MSB distinguishes full from empty.
  - `dout` = `mem[rp]`, first-word-fall-through.
  - A push when full without a same-cycle pop drops the byte and sets `ovr`.
  - A push and pop in the same cycle when full both succeed; `ovr` is not set.
  - `rd` when empty is ignored.
  - If `rd` and the overrun set happen in the same cycle, set wins.

## Timing
- Reset values:
  - `rdy`=0, `dout`=0x00, `ferr`=0, `ovr`=0.
  - FSM in IDLE, pointers 0, synchroniser flops 1.
- Reset asserted mid-frame abandons the frame. The buffered bytes are lost.
- Latency:
  - `rxs` lags `rx` by 2 clocks.
  - `rdy` rises 1 clock after the stop-bit sample cycle, about 9.5 bit times after the start edge.
- `rd` semantics:
  - Sampled on a rising edge.
  - The next byte appears on `dout` on the following clock.
  - `rdy` falls on the following clock if the FIFO becomes empty.
- `ferr` is high for exactly one clock, coincident with the push-cycle slot.
- Back-to-back frames: the next start edge is accepted the cycle after STOP exits.

## Configuration
- `UART_RX_FIFO_EN` defined: `DEPTH`-entry FIFO as described.
- Undefined: single holding register with a valid flag.
  - Push into a full register overwrites the held byte and sets `ovr`.
  - A same-cycle `rd` and push loads the new byte with no `ovr`.
  - `DEPTH` is ignored.

## Test plan
- Reset, then send 0x41 at 9600 baud → `rdy`=1 about 9.5 bit times after the start edge, `dout`=0x41. `rd` pulse → `rdy`=0 next clock.
- 2 µs low glitch on idle `rx` → no `rdy`, no `ferr`. A following 0x0D is received correctly.
- Frame 0x55 with the stop bit held low for one bit then released high → `ferr` one-clock pulse, `rdy` stays 0. Next frame 0x33 → `dout`=0x33.
- FIFO build: send 0x10, 0x11, 0x12, 0x13, 0x14 with no reads → read order 0x10–0x13, 0x14 lost, `ovr`=1 until the first `rd`.
- FIFO full, with `rd` asserted exactly on the push cycle of 0x20 → 0x20 stored, `ovr`=0, four bytes remain.
- Assert `rst` during data bit 3 of a frame → all outputs return to reset values. The next frame 0x7E is received intact.
